// File: rtl/stack_access_unit_if.sv
// Bundle between the control unit, the stack pointer block, the data memory
// and the stack access unit; the unit sits on the slave side.
interface stack_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
);
    logic              req;
    logic              op;
    logic [DATA_W-1:0] wrData;
    logic              ready;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdData;
    logic [31:0]       SP;
    logic              empty;
    logic              full;
    logic [1:0]        spOp;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWrData;
    logic              memWrEn;
    logic              memRdEn;
    logic [DATA_W-1:0] memRdData;
    logic [ERR_W-1:0]  errCount;

    modport slave (
        input  req, op, wrData, SP, empty, full, memRdData,
        output ready, done, err, rdData, spOp,
        output memAddr, memWrData, memWrEn, memRdEn, errCount
    );

    modport master (
        output req, op, wrData, SP, empty, full, memRdData,
        input  ready, done, err, rdData, spOp,
        input  memAddr, memWrData, memWrEn, memRdEn, errCount
    );
endinterface

// File: rtl/stack_access_unit.sv
// Push/pop sequencer: checks empty/full, drives the SP command and the
// matching data-memory access, returns popped data and counts rejects.
module stack_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input logic                clock,
    input logic                reset,
    stack_access_unit_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        PUSH_WR,
        POP_RD,
        POP_WAIT,
        DONE
    } state_t;

    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_PUSH = 2'b01;
    localparam logic [1:0] SP_POP  = 2'b10;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic [ERR_W-1:0]  errcnt_q, errcnt_d;
    logic [ERR_W-1:0]  errcnt_inc;
    logic              errflag_q, errflag_d;
    logic [31:0]       sp_dec;
    logic              wr_en;
    logic              rd_en;
    logic              done_c;
    logic [1:0]        sp_op;
    logic [ADDR_W-1:0] addr;
    logic              unused_sp;

    // Pop reads the word just below the next-free slot.
    assign sp_dec = bus.SP - 32'd1;
    assign unused_sp = ^{bus.SP[31:ADDR_W], sp_dec[31:ADDR_W]};

    // Reject counter sticks at all-ones.
    assign errcnt_inc = (&errcnt_q) ? errcnt_q : errcnt_q + ERR_W'(1);

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            wdat_q    <= '0;
            rdat_q    <= '0;
            errcnt_q  <= '0;
            errflag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            errcnt_q  <= errcnt_d;
            errflag_q <= errflag_d;
        end
    end

    // Next state, datapath updates and raw strobes
    always_comb begin
        state_d   = state_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        errcnt_d  = errcnt_q;
        errflag_d = errflag_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        done_c    = 1'b0;
        sp_op     = SP_HOLD;
        addr      = bus.SP[ADDR_W-1:0];
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (!bus.op) begin
                        if (bus.full) begin
                            errflag_d = 1'b1;
                            errcnt_d  = errcnt_inc;
                            state_d   = DONE;
                        end else begin
                            wdat_d  = bus.wrData;
                            state_d = PUSH_WR;
                        end
                    end else begin
                        if (bus.empty) begin
                            errflag_d = 1'b1;
                            errcnt_d  = errcnt_inc;
                            state_d   = DONE;
                        end else begin
                            state_d = POP_RD;
                        end
                    end
                end
            end
            PUSH_WR: begin
                wr_en   = 1'b1;
                sp_op   = SP_PUSH;
                state_d = DONE;
            end
            POP_RD: begin
                rd_en   = 1'b1;
                addr    = sp_dec[ADDR_W-1:0];
                sp_op   = SP_POP;
                state_d = POP_WAIT;
            end
            POP_WAIT: begin
                rdat_d  = bus.memRdData;
                state_d = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                errflag_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are gated by reset so a reset mid-operation commits nothing.
    assign bus.ready     = (state_q == IDLE);
    assign bus.done      = done_c & reset;
    assign bus.err       = done_c & errflag_q & reset;
    assign bus.spOp      = reset ? sp_op : SP_HOLD;
    assign bus.memWrEn   = wr_en & reset;
    assign bus.memRdEn   = rd_en & reset;
    assign bus.memAddr   = addr;
    assign bus.memWrData = wdat_q;
    assign bus.rdData    = rdat_q;
    assign bus.errCount  = errcnt_q;
endmodule

// File: doc/stack_access_unit.md
Name: stack_access_unit

Overview:
- Sequencer between the control unit and the stack pointer / data memory pair.
- Accepts single PUSH/POP requests and reads the current SP plus empty/full flags from the stack pointer block.
- Drives the 2-bit SP update command back to the stack pointer block and performs the matching data-memory word write or read.
- Returns popped data and flags overflow/underflow without touching memory or SP.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 8, data memory address width; the memory address is the low ADDR_W bits of the computed stack address.
- ERR_W, 8, width of the saturating fault counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  1  request valid; sampled only when ready=1.
- op  in  1  0 = PUSH, 1 = POP.
- wrData  in  DATA_W  value to push.
- ready  out  1  unit idle and able to accept a request.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = request rejected (overflow or underflow).
- rdData  out  DATA_W  popped value; valid with done when op was POP and err=0; holds its value until the next successful pop.
- SP  in  32  current stack pointer; points to the next free word.
- empty  in  1  stack empty flag from the stack pointer block.
- full  in  1  stack full flag from the stack pointer block.
- spOp  out  2  SP command: 2'b00 hold, 2'b01 push (SP+1), 2'b10 pop (SP-1); 2'b11 is never driven.
- memAddr  out  ADDR_W  data memory address.
- memWrData  out  DATA_W  data memory write data.
- memWrEn  out  1  data memory write strobe.
- memRdEn  out  1  data memory read strobe.
- memRdData  in  DATA_W  synchronous read data, valid one cycle after memRdEn.
- errCount  out  ERR_W  count of rejected requests; saturates at all-ones.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state goes to IDLE; rdData, errCount and the latched write data clear to 0.
  - memWrEn, memRdEn, done and err are combinationally forced to 0, and spOp to 2'b00, whenever reset=0, so a reset arriving mid-operation never commits a write or an SP change.
- FSM states: IDLE, PUSH_WR, POP_RD, POP_WAIT, DONE.
- IDLE:
  - ready=1; all strobes 0; spOp=00.
  - On req=1 with op=0: if full=1, record an error and go to DONE; otherwise latch wrData and go to PUSH_WR.
  - On req=1 with op=1: if empty=1, record an error and go to DONE; otherwise go to POP_RD.
- PUSH_WR:
  - memWrEn=1, memAddr=SP[ADDR_W-1:0], memWrData=latched data, spOp=01.
  - Next state DONE.
- POP_RD:
  - memRdEn=1, memAddr=(SP-1)[ADDR_W-1:0] (32-bit subtract, then truncate), spOp=10.
  - Next state POP_WAIT.
- POP_WAIT:
  - Strobes 0, spOp=00; rdData is loaded from memRdData at the end of this cycle.
  - Next state DONE.
- DONE:
  - done=1; err reflects the recorded error flag; ready=0.
  - Next state IDLE; the error flag clears on leaving DONE.
- Latency from the accept edge to done high:
  - PUSH: 2 cycles.
  - POP: 3 cycles.
  - Rejected request: 1 cycle.
- Throughput: a new request can be accepted in the cycle after done.
- req while ready=0 is ignored; there is no queueing, and the requester must hold req until it sees ready.
- Fault counter: errCount increments by 1 on each rejected request and saturates at 2^ERR_W-1.
- Address wrap: when SP exceeds the memory depth, the address wraps modulo 2^ADDR_W; overflow protection relies only on full.
- Ordering: spOp is asserted exactly one cycle per successful operation, so SP has updated by the cycle after PUSH_WR/POP_RD; the memory address always uses the pre-update SP.
- Flags: empty and full are sampled only in IDLE at acceptance; changes in other states are ignored.
- Simultaneous full and empty (illegal): PUSH is rejected on full and POP on empty, independently.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 2 cycles, then release.
  - Required: ready=1, done=0, spOp=00, errCount=0, rdData=0.
- PUSH:
  - Stimulus: SP=0, empty=1, full=0, req=1, op=0, wrData=32'hDEADBEEF.
  - Required: next cycle memWrEn=1, memAddr=0, memWrData=DEADBEEF, spOp=01; done=1 with err=0 two cycles after accept.
- PUSH-PUSH-POP:
  - Stimulus: push 32'h11 then 32'h22 with the model SP advancing 0→1→2, then POP at SP=2.
  - Required: memAddr=1 with memRdEn=1 and spOp=10; done after 3 cycles with rdData=32'h22.
- Underflow:
  - Stimulus: POP with empty=1.
  - Required: no memWrEn/memRdEn, spOp stays 00; done=1 and err=1 one cycle after accept; errCount=1.
- Overflow and saturation:
  - Stimulus: ERR_W=2, issue 5 PUSHes with full=1.
  - Required: five err pulses, errCount saturates at 3, and memory/SP are untouched.
- Reset mid-POP:
  - Stimulus: assert reset=0 during POP_RD.
  - Required: memRdEn and spOp are forced 0 that cycle, state returns to IDLE, no done pulse, rdData=0.
